// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS opcode/funct constants, request kinds and loader states
// Contents:
//   OP_*     6-bit primary opcodes
//   FN_*     6-bit R-type funct codes
//   kind_e   in_kind request encoding (10..15 are illegal)
//   state_e  loader FSM encoding; ST_PAD exists only with LOADER_NOP_PAD_EN
//   rtype()  R-type word builder
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    KIND_ADD  = 4'd0,
    KIND_SUB  = 4'd1,
    KIND_AND  = 4'd2,
    KIND_OR   = 4'd3,
    KIND_SLT  = 4'd4,
    KIND_LW   = 4'd5,
    KIND_SW   = 4'd6,
    KIND_BEQ  = 4'd7,
    KIND_ADDI = 4'd8,
    KIND_J    = 4'd9
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
`ifdef LOADER_NOP_PAD_EN
    , ST_PAD = 2'd3
`endif
  } state_e;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'b00000, fn};
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - combinational field-to-word MIPS instruction encoder
// Ports:
//   kind     in   4   request kind (kind_e); 10..15 illegal
//   rs/rt/rd in   5   register fields (rd used by R-type only)
//   imm      in   26  imm[15:0] for I-type, imm[25:0] jump target
//   word     out  32  encoded instruction, 32'h0 for illegal kinds
//   illegal  out  1   kind is not a recognised instruction
module instr_encoder
  import mips_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    case (kind_e'(kind))
      KIND_ADD:  word = rtype(rs, rt, rd, FN_ADD);
      KIND_SUB:  word = rtype(rs, rt, rd, FN_SUB);
      KIND_AND:  word = rtype(rs, rt, rd, FN_AND);
      KIND_OR:   word = rtype(rs, rt, rd, FN_OR);
      KIND_SLT:  word = rtype(rs, rt, rd, FN_SLT);
      KIND_LW:   word = {OP_LW,   rs, rt, imm[15:0]};
      KIND_SW:   word = {OP_SW,   rs, rt, imm[15:0]};
      KIND_BEQ:  word = {OP_BEQ,  rs, rt, imm[15:0]};
      KIND_ADDI: word = {OP_ADDI, rs, rt, imm[15:0]};
      KIND_J:    word = {OP_J, imm};
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - streams field-level requests into instruction memory as MIPS words
// Optional feature macro: LOADER_NOP_PAD_EN (pad remaining words with NOPs after in_last).
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   start                  pulse; begin a load at address 0 (ignored while loading)
//   in_valid/in_ready      request handshake
//   in_kind,in_rs,in_rt,in_rd,in_imm,in_last   request fields
//   imem_we/imem_addr/imem_wdata   registered instruction memory write port
//   cpu_hold, done         CPU gate and completion, both registered
//   err                    sticky illegal-kind flag for the current load
//   count                  words written during the current load
module instr_loader
  import mips_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [25:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e            state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              accept;
  logic              fill;

  instr_encoder u_enc (
    .kind    (in_kind),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .imm     (in_imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // Derived from registered count, so ready falls in the same cycle count hits DEPTH.
  assign in_ready = (state == ST_LOAD) && (count < DEPTH_C);
  assign accept   = in_valid && in_ready;
  // The write being issued this cycle is the one that fills memory.
  assign fill     = (count + (ADDR_W+1)'(1)) == DEPTH_C;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      count      <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          done     <= 1'b0;
          cpu_hold <= 1'b1;
          if (start) begin
            state <= ST_LOAD;
            count <= '0;
            err   <= 1'b0;
            ptr   <= '0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            imem_we    <= 1'b1;
            imem_addr  <= ptr;
            imem_wdata <= enc_word;
            ptr        <= ptr + ADDR_W'(1);
            count      <= count + (ADDR_W+1)'(1);
            if (enc_illegal) err <= 1'b1;
            if (fill) begin
              state <= ST_DONE;
            end else if (in_last) begin
`ifdef LOADER_NOP_PAD_EN
              state <= ST_PAD;
`else
              state <= ST_DONE;
`endif
            end
          end
        end
`ifdef LOADER_NOP_PAD_EN
        ST_PAD: begin
          imem_we    <= 1'b1;
          imem_addr  <= ptr;
          imem_wdata <= 32'h0;
          ptr        <= ptr + ADDR_W'(1);
          count      <= count + (ADDR_W+1)'(1);
          if (fill) state <= ST_DONE;
        end
`endif
        ST_DONE: begin
          // Entered alongside the final write, so done lags that write by a cycle.
          done     <= 1'b1;
          cpu_hold <= 1'b0;
          if (start) begin
            state    <= ST_LOAD;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
            count    <= '0;
            err      <= 1'b0;
            ptr      <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed self-checking bench for instr_loader (64, 4 and 8 word instances)
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [25:0] in_imm;
  logic        in_last;

  logic        start_a, start_s, start_p;
  logic        rdy_a, rdy_s, rdy_p;
  logic        we_a, we_s, we_p;
  logic [5:0]  addr_a;
  logic [1:0]  addr_s;
  logic [2:0]  addr_p;
  logic [31:0] wd_a, wd_s, wd_p;
  logic        hold_a, hold_s, hold_p;
  logic        done_a, done_s, done_p;
  logic        err_a, err_s, err_p;
  logic [6:0]  cnt_a;
  logic [2:0]  cnt_s;
  logic [3:0]  cnt_p;

  int compared   = 0;
  int mismatched = 0;

  int          wc_s = 0;
  int          wc_p = 0;
  logic [31:0] log_s [4];
  logic [31:0] log_p [8];

  always #5 clk = ~clk;

  instr_loader #(.DEPTH(64), .ADDR_W(6)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid), .in_ready(rdy_a),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a),
    .cpu_hold(hold_a), .done(done_a), .err(err_a), .count(cnt_a));

  instr_loader #(.DEPTH(4), .ADDR_W(2)) u_s (
    .clk(clk), .reset(reset), .start(start_s), .in_valid(in_valid), .in_ready(rdy_s),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .imem_we(we_s), .imem_addr(addr_s), .imem_wdata(wd_s),
    .cpu_hold(hold_s), .done(done_s), .err(err_s), .count(cnt_s));

  instr_loader #(.DEPTH(8), .ADDR_W(3)) u_p (
    .clk(clk), .reset(reset), .start(start_p), .in_valid(in_valid), .in_ready(rdy_p),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .imem_we(we_p), .imem_addr(addr_p), .imem_wdata(wd_p),
    .cpu_hold(hold_p), .done(done_p), .err(err_p), .count(cnt_p));

  always @(negedge clk) begin
    if (we_s) begin
      log_s[addr_s] = wd_s;
      wc_s = wc_s + 1;
    end
    if (we_p) begin
      log_p[addr_p] = wd_p;
      wc_p = wc_p + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [25:0] imm, input logic last);
    in_valid = 1'b1;
    in_kind  = k;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_imm   = imm;
    in_last  = last;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int which, input int max_cycles);
    int   n;
    logic d;
    n = 0;
    d = (which == 0) ? done_a : (which == 1) ? done_s : done_p;
    while (!d && n < max_cycles) begin
      tick();
      n++;
      d = (which == 0) ? done_a : (which == 1) ? done_s : done_p;
    end
    chk("done_wait", {31'b0, d}, 32'd1);
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0; start_s = 1'b0; start_p = 1'b0;
    in_valid = 1'b0; in_kind = 4'd0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_imm = '0; in_last = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_ready", {31'b0, rdy_a}, 32'd0);
    chk("rst_we",    {31'b0, we_a},  32'd0);
    chk("rst_addr",  {26'b0, addr_a}, 32'd0);
    chk("rst_wdata", wd_a, 32'h0);
    chk("rst_hold",  {31'b0, hold_a}, 32'd1);
    chk("rst_done",  {31'b0, done_a}, 32'd0);
    chk("rst_err",   {31'b0, err_a},  32'd0);
    chk("rst_count", {25'b0, cnt_a},  32'd0);

    reset = 1'b0;
    tick();
    chk("idle_ignores_valid", {31'b0, rdy_a}, 32'd0);

    // single ADD with in_last
    pulse_start_a();
    chk("load_ready", {31'b0, rdy_a}, 32'd1);
    beat(4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1);
    tick();
    idle_in();
    chk("add_we",    {31'b0, we_a}, 32'd1);
    chk("add_addr",  {26'b0, addr_a}, 32'd0);
    chk("add_wdata", wd_a, 32'h00221820);
    chk("add_done_not_yet", {31'b0, done_a}, 32'd0);
    chk("add_hold_not_yet", {31'b0, hold_a}, 32'd1);
`ifdef LOADER_NOP_PAD_EN
    wait_done(0, 200);
    chk("add_count_pad", {25'b0, cnt_a}, 32'd64);
`else
    tick();
    chk("add_done", {31'b0, done_a}, 32'd1);
    chk("add_hold", {31'b0, hold_a}, 32'd0);
    chk("add_count", {25'b0, cnt_a}, 32'd1);
    chk("done_ready", {31'b0, rdy_a}, 32'd0);
`endif

    // back-to-back LW / SW / BEQ
    pulse_start_a();
    chk("reload_done_clear", {31'b0, done_a}, 32'd0);
    beat(4'd5, 5'd0, 5'd8, 5'd0, 26'd4, 1'b0);
    tick();
    chk("lw_we", {31'b0, we_a}, 32'd1);
    chk("lw_addr", {26'b0, addr_a}, 32'd0);
    chk("lw_wdata", wd_a, 32'h8C080004);
    beat(4'd6, 5'd0, 5'd8, 5'd0, 26'd8, 1'b0);
    tick();
    chk("sw_we", {31'b0, we_a}, 32'd1);
    chk("sw_addr", {26'b0, addr_a}, 32'd1);
    chk("sw_wdata", wd_a, 32'hAC080008);
    beat(4'd7, 5'd1, 5'd2, 5'd0, 26'h000FFFF, 1'b1);
    tick();
    idle_in();
    chk("beq_we", {31'b0, we_a}, 32'd1);
    chk("beq_addr", {26'b0, addr_a}, 32'd2);
    chk("beq_wdata", wd_a, 32'h1022FFFF);
    wait_done(0, 200);

    // illegal kind mid-stream
    pulse_start_a();
    chk("start_clears_err", {31'b0, err_a}, 32'd0);
    beat(4'd5, 5'd0, 5'd8, 5'd0, 26'd4, 1'b0);
    tick();
    chk("ill_pre_wdata", wd_a, 32'h8C080004);
    chk("ill_pre_err", {31'b0, err_a}, 32'd0);
    beat(4'd12, 5'd7, 5'd7, 5'd7, 26'h3FFFFFF, 1'b0);
    tick();
    chk("ill_we", {31'b0, we_a}, 32'd1);
    chk("ill_addr", {26'b0, addr_a}, 32'd1);
    chk("ill_wdata", wd_a, 32'h0);
    chk("ill_err", {31'b0, err_a}, 32'd1);
    chk("ill_count", {25'b0, cnt_a}, 32'd2);
    beat(4'd8, 5'd1, 5'd2, 5'd0, 26'd5, 1'b1);
    tick();
    idle_in();
    chk("addi_addr", {26'b0, addr_a}, 32'd2);
    chk("addi_wdata", wd_a, 32'h20220005);
    chk("err_sticky", {31'b0, err_a}, 32'd1);
    wait_done(0, 200);
    chk("err_sticky_done", {31'b0, err_a}, 32'd1);

    // reset during load after two writes
    pulse_start_a();
    beat(4'd1, 5'd4, 5'd5, 5'd6, 26'd0, 1'b0);
    tick();
    beat(4'd2, 5'd4, 5'd5, 5'd6, 26'd0, 1'b0);
    tick();
    chk("pre_reset_addr", {26'b0, addr_a}, 32'd1);
    chk("pre_reset_wdata", wd_a, 32'h00853024);
    reset = 1'b1;
    #1;
    idle_in();
    chk("abort_we", {31'b0, we_a}, 32'd0);
    chk("abort_done", {31'b0, done_a}, 32'd0);
    chk("abort_hold", {31'b0, hold_a}, 32'd1);
    chk("abort_count", {25'b0, cnt_a}, 32'd0);
    chk("abort_ready", {31'b0, rdy_a}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    pulse_start_a();
    beat(4'd4, 5'd9, 5'd10, 5'd11, 26'd0, 1'b1);
    tick();
    idle_in();
    chk("resume_addr", {26'b0, addr_a}, 32'd0);
    chk("resume_wdata", wd_a, 32'h012A582A);
    wait_done(0, 200);

    // DEPTH=4: six beats without in_last
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int i = 0; i < 6; i++) begin
      beat(4'd3, 5'(i), 5'd1, 5'd2, 26'd0, 1'b0);
      tick();
      if (i == 3) chk("full_ready_low", {31'b0, rdy_s}, 32'd0);
    end
    idle_in();
    tick();
    chk("full_writes", wc_s, 32'd4);
    chk("full_done", {31'b0, done_s}, 32'd1);
    chk("full_count", {29'b0, cnt_s}, 32'd4);
    chk("full_word3", log_s[3], 32'h00611025);

    // DEPTH=8: J with in_last
    start_p = 1'b1;
    tick();
    start_p = 1'b0;
    beat(4'd9, 5'd0, 5'd0, 5'd0, 26'h0000010, 1'b1);
    tick();
    idle_in();
    chk("j_addr", {29'b0, addr_p}, 32'd0);
    chk("j_wdata", wd_p, 32'h08000010);
    wait_done(2, 50);
`ifdef LOADER_NOP_PAD_EN
    chk("pad_writes", wc_p, 32'd8);
    chk("pad_count", {28'b0, cnt_p}, 32'd8);
    for (int a = 1; a < 8; a++) chk("pad_word", log_p[a], 32'h0);
`else
    chk("nopad_writes", wc_p, 32'd1);
    chk("nopad_count", {28'b0, cnt_p}, 32'd1);
`endif
    chk("j_hold", {31'b0, hold_p}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer side of the instruction path. The control unit decodes OpCode/Funct out of instruction words; this block produces those words.
- Accepts field-level instruction requests over a valid/ready stream, encodes each into a 32-bit MIPS word, and writes the words sequentially into instruction memory.
- Holds the CPU in hold until loading finishes. Sits between the testbench/host loader port and the instruction memory write port.

Parameters:
- DEPTH, 64, instruction memory depth in words.
- ADDR_W, 6, word-address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load at address 0.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_kind  input  4  instruction kind code (see Behaviour).
- in_rs  input  5  rs field.
- in_rt  input  5  rt field.
- in_rd  input  5  rd field (R-type only).
- in_imm  input  26  imm[15:0] for I-type; imm[25:0] target for J.
- in_last  input  1  marks the final request of the program.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  ADDR_W  word address.
- imem_wdata  output  32  encoded instruction.
- cpu_hold  output  1  high while the CPU must not fetch.
- done  output  1  load complete.
- err  output  1  sticky illegal-kind flag.
- count  output  ADDR_W+1  words written this load.

Behaviour:
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, err=0, count=0.
- States:
  - IDLE: cpu_hold=1. On start -> LOAD; clear count, err and the address pointer.
  - LOAD: in_ready = (count < DEPTH). On an accepted beat: write the encoded word, increment the pointer. If in_last is set, or the beat fills DEPTH -> DONE (or PAD, see Optional Feature).
  - DONE: done=1, cpu_hold=0, in_ready=0. On start -> LOAD (reload from 0).
- Encoding (in_kind):
  - 0 ADD {000000,rs,rt,rd,00000,100000}
  - 1 SUB funct 100010
  - 2 AND funct 100100
  - 3 OR funct 100101
  - 4 SLT funct 101010
  - 5 LW {100011,rs,rt,imm[15:0]}
  - 6 SW 101011
  - 7 BEQ 000100
  - 8 ADDI 001000
  - 9 J {000010,imm[25:0]}
  - 10-15 illegal: word written as 32'h0 (NOP), err set sticky, count still increments.
- Latency: a beat accepted at cycle N gives imem_we=1 with registered addr/wdata in cycle N+1. Output is single-cycle pulses; back-to-back beats yield consecutive writes.
- Full: when count reaches DEPTH, in_ready drops in the same cycle the count updates. The state goes to DONE even without in_last.
- start while in LOAD is ignored. in_valid outside LOAD is ignored.
- done and cpu_hold update in the cycle after the last write is issued, so the CPU never sees a partial program.
- Reset mid-load aborts immediately. Written words remain in memory; all outputs return to reset values.

Optional Feature:
- LOADER_NOP_PAD_EN defined: after in_last with count < DEPTH, enter PAD. PAD writes 32'h0 at each remaining address, one per cycle, with in_ready=0, then goes to DONE. count ends at DEPTH.
- Not defined: no PAD state; DONE follows in_last directly, and count equals the number of requests.

Decomposition:
- Package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - funct constants: FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT;
  - the in_kind enumeration and the state encoding.
- One combinational sub-module, instr_encoder (kind + fields -> 32-bit word + illegal flag), reused by benches as a golden encoder.

Test Plan:
- Reset then start; send ADD rs=1 rt=2 rd=3, in_last=1 -> one write, addr 0, wdata 32'h00221820; done=1, cpu_hold=0 next cycle; count=1.
- Stream LW rs=0 rt=8 imm=4, SW rs=0 rt=8 imm=8, BEQ rs=1 rt=2 imm=16'hFFFF back-to-back -> wdata 32'h8C080004, 32'hAC080008, 32'h1022FFFF at addr 0,1,2 in consecutive cycles.
- DEPTH=4: send 6 beats without in_last -> exactly 4 writes; in_ready low after the 4th; done=1; count=4.
- in_kind=12 mid-stream -> that address gets 32'h0; err=1 and stays set; following words are written correctly.
- Assert reset during LOAD after 2 writes -> imem_we=0, done=0, cpu_hold=1, count=0. Restart with start -> writes resume at addr 0.
- With LOADER_NOP_PAD_EN, DEPTH=8: send J imm=26'h0000010 with in_last -> wdata 32'h08000010 at addr 0; addrs 1-7 get 32'h0; done after 8 writes total.
